// File: rtl/rs_pkg.sv
// Shared types and helpers for the row realigner.
// FSM encoding, default geometry and lane selection.
package rs_pkg;

    localparam int LANE_WIDTH_DEF = 32;
    localparam int LANES_DEF      = 4;
    localparam int MAX_DWIDTH     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS,
        ST_BOUNDARY,
        ST_SHIFT,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Lane i of a row, right-aligned; caller truncates to its lane width.
    function automatic logic [MAX_DWIDTH-1:0] LANE_SEL(
        input logic [MAX_DWIDTH-1:0] row,
        input int                    i,
        input int                    lw
    );
        return row >> (i * lw);
    endfunction

endpackage

// File: rtl/lane_rotator.sv
// Combinational lane shifter: low s lanes come from the carry,
// the rest from the row; the row's top s lanes form the next carry.
module lane_rotator
    import rs_pkg::*;
#(
    parameter int LANE_WIDTH = LANE_WIDTH_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int DWIDTH     = LANE_WIDTH * LANES,
    parameter int SHWIDTH    = $clog2(LANES)
) (
    input  logic [DWIDTH-1:0]  carry,
    input  logic [DWIDTH-1:0]  row,
    input  logic [SHWIDTH-1:0] s,
    output logic [DWIDTH-1:0]  shifted,
    output logic [DWIDTH-1:0]  next_carry
);

    // Per-lane mux selecting carry or row lane by shift amount.
    always_comb begin
        shifted    = '0;
        next_carry = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(s)) begin
                shifted[i*LANE_WIDTH +: LANE_WIDTH] =
                    LANE_WIDTH'(LANE_SEL(MAX_DWIDTH'(carry), i, LANE_WIDTH));
                next_carry[i*LANE_WIDTH +: LANE_WIDTH] =
                    LANE_WIDTH'(LANE_SEL(MAX_DWIDTH'(row),
                                         LANES - int'(s) + i, LANE_WIDTH));
            end else begin
                shifted[i*LANE_WIDTH +: LANE_WIDTH] =
                    LANE_WIDTH'(LANE_SEL(MAX_DWIDTH'(row),
                                         i - int'(s), LANE_WIDTH));
            end
        end
    end

endmodule

// File: rtl/row_realigner.sv
// Streams a bucket: pass rows, absorb a boundary row, lane-shift
// the remaining rows, then flush the carry as the final row.
module row_realigner
    import rs_pkg::*;
#(
    parameter int LANE_WIDTH = LANE_WIDTH_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int DWIDTH     = LANE_WIDTH * LANES,
    parameter int CNTWIDTH   = 18,
    parameter int SHWIDTH    = $clog2(LANES)
) (
    input  logic                I_ACLK,
    input  logic                I_ARESET,
    input  logic                I_START,
    input  logic [CNTWIDTH-1:0] I_PASS_ROWS,
    input  logic [CNTWIDTH-1:0] I_SHIFT_ROWS,
    input  logic [SHWIDTH-1:0]  I_SHIFT,
    input  logic                I_IN_VALID,
    output logic                O_IN_READY,
    input  logic [DWIDTH-1:0]   I_IN_DATA,
    output logic                O_OUT_VALID,
    input  logic                I_OUT_READY,
    output logic [DWIDTH-1:0]   O_OUT_DATA,
    output logic                O_OUT_LAST,
    output logic                O_BUSY,
    output logic                O_DONE
);

    state_t              state, state_n;
    logic                start_q;
    logic                start_edge;
    logic [CNTWIDTH-1:0] pass_q, srows_q;
    logic [SHWIDTH-1:0]  sh_q;
    logic [CNTWIDTH-1:0] cnt, cnt_n;
    logic [DWIDTH-1:0]   carry, carry_n;
    logic [DWIDTH-1:0]   rot_row, rot_carry, flush_row, flush_unused;
    logic                out_free, accept;
    logic                load, load_last, done_n;
    logic [DWIDTH-1:0]   load_data;

    assign start_edge = I_START && !start_q;
    assign out_free   = !O_OUT_VALID || I_OUT_READY;
    assign O_IN_READY = out_free && (state == ST_PASS ||
                                     state == ST_BOUNDARY ||
                                     state == ST_SHIFT);
    assign accept     = I_IN_VALID && O_IN_READY;
    assign O_BUSY     = (state != ST_IDLE);

    lane_rotator #(
        .LANE_WIDTH(LANE_WIDTH), .LANES(LANES),
        .DWIDTH(DWIDTH), .SHWIDTH(SHWIDTH)
    ) u_rot (
        .carry(carry), .row(I_IN_DATA), .s(sh_q),
        .shifted(rot_row), .next_carry(rot_carry)
    );

    // Flush row is the carry shifted in against an all-zero row.
    lane_rotator #(
        .LANE_WIDTH(LANE_WIDTH), .LANES(LANES),
        .DWIDTH(DWIDTH), .SHWIDTH(SHWIDTH)
    ) u_flush (
        .carry(carry), .row('0), .s(sh_q),
        .shifted(flush_row), .next_carry(flush_unused)
    );

    // Next-state, counter, carry and output-load decisions.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        carry_n   = carry;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        done_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (start_edge) begin
                    if (I_PASS_ROWS != '0)       state_n = ST_PASS;
                    else if (I_SHIFT != '0)      state_n = ST_BOUNDARY;
                    else if (I_SHIFT_ROWS != '0) state_n = ST_SHIFT;
                    else                         state_n = ST_DONE;
                end
            end
            ST_PASS: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = I_IN_DATA;
                    if (cnt == pass_q - 1'b1) begin
                        cnt_n     = '0;
                        load_last = (sh_q == '0) && (srows_q == '0);
                        if (sh_q != '0)         state_n = ST_BOUNDARY;
                        else if (srows_q != '0) state_n = ST_SHIFT;
                        else                    state_n = ST_DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_BOUNDARY: begin
                if (accept) begin
                    carry_n = I_IN_DATA;
                    state_n = (srows_q != '0) ? ST_SHIFT : ST_FLUSH;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = rot_row;
                    carry_n   = rot_carry;
                    if (cnt == srows_q - 1'b1) begin
                        cnt_n     = '0;
                        load_last = (sh_q == '0);
                        state_n   = (sh_q != '0) ? ST_FLUSH : ST_DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = flush_row;
                    load_last = 1'b1;
                    state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (O_DONE)        state_n = ST_IDLE;
                else if (out_free) done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, job parameters, carry and the single output register.
    always_ff @(posedge I_ACLK) begin
        if (I_ARESET) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            pass_q      <= '0;
            srows_q     <= '0;
            sh_q        <= '0;
            cnt         <= '0;
            carry       <= '0;
            O_OUT_VALID <= 1'b0;
            O_OUT_DATA  <= '0;
            O_OUT_LAST  <= 1'b0;
            O_DONE      <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= I_START;
            cnt     <= cnt_n;
            carry   <= carry_n;
            O_DONE  <= done_n;
            if (state == ST_IDLE && start_edge) begin
                pass_q  <= I_PASS_ROWS;
                srows_q <= I_SHIFT_ROWS;
                sh_q    <= I_SHIFT;
            end
            if (load) begin
                O_OUT_VALID <= 1'b1;
                O_OUT_DATA  <= load_data;
                O_OUT_LAST  <= load_last;
            end else if (I_OUT_READY) begin
                O_OUT_VALID <= 1'b0;
                O_OUT_LAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_row_realigner.sv
// Directed bench for row_realigner with a scoreboard of expected
// output rows and a per-cycle monitor on the falling edge.
module tb_row_realigner;

    localparam int LW = 32;
    localparam int NL = 4;
    localparam int DW = LW * NL;
    localparam int CW = 18;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] pass_rows = '0;
    logic [CW-1:0] shift_rows = '0;
    logic [SW-1:0] shift = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    row_realigner dut (
        .I_ACLK(clk), .I_ARESET(rst), .I_START(start),
        .I_PASS_ROWS(pass_rows), .I_SHIFT_ROWS(shift_rows),
        .I_SHIFT(shift), .I_IN_VALID(in_valid), .O_IN_READY(in_ready),
        .I_IN_DATA(in_data), .O_OUT_VALID(out_valid),
        .I_OUT_READY(out_ready), .O_OUT_DATA(out_data),
        .O_OUT_LAST(out_last), .O_BUSY(busy), .O_DONE(done)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] src[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0, busy_cyc = 0, n_out = 0, n_in = 0, last_cnt = 0;
    int done_cnt = 0, done_cyc = 0, last_hs = 0, start_cyc = 0;
    bit seen_valid = 0, rnd_rdy = 0, gaps = 0, prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk(int l3, int l2, int l1, int l0);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [LW-1:0] lane(logic [DW-1:0] r, int i);
        return r[i*LW +: LW];
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Reference model of a whole job over the rows in src.
    task automatic model(input int p, input int sr, input int s);
        int idx = 0;
        logic [DW-1:0] c = '0, o, nc, r;
        for (int k = 0; k < p; k++) begin
            push_exp(src[idx], s == 0 && sr == 0 && k == p - 1);
            idx++;
        end
        if (s != 0) begin
            c = src[idx];
            idx++;
        end
        for (int j = 0; j < sr; j++) begin
            r = src[idx];
            idx++;
            o = '0;
            nc = '0;
            for (int i = 0; i < NL; i++)
                o[i*LW +: LW] = (i < s) ? lane(c, i) : lane(r, i - s);
            for (int i = 0; i < s; i++)
                nc[i*LW +: LW] = lane(r, NL - s + i);
            c = nc;
            push_exp(o, s == 0 && j == sr - 1);
        end
        if (s != 0) begin
            o = '0;
            for (int i = 0; i < s; i++) o[i*LW +: LW] = lane(c, i);
            push_exp(o, 1'b1);
        end
    endtask

    task automatic monitor();
        exp_t e;
        cyc++;
        if (rst) begin
            prev_stall = 0;
            return;
        end
        if (busy) busy_cyc++;
        if (out_valid) seen_valid = 1;
        if (prev_stall) begin
            chk("stall_valid", DW'(out_valid), DW'(1));
            chk("stall_data", out_data, prev_data);
            chk("stall_last", DW'(out_last), DW'(prev_last));
        end
        if (out_valid && out_ready) begin
            n_out++;
            last_hs = cyc;
            if (out_last) last_cnt++;
            if (exp_q.size() == 0) begin
                chk("exp_avail", DW'(exp_q.size()), DW'(1));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", DW'(out_last), DW'(e.last));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (in_valid && in_ready) begin
            n_in++;
            if (in_q.size() > 0) void'(in_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        in_valid  = in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0);
        in_data   = (in_q.size() > 0) ? in_q[0] : '0;
        out_ready = !rnd_rdy || $urandom_range(0, 1) == 1;
    endtask

    task automatic start_job(input int p, input int sr, input int s);
        pass_rows  = CW'(p);
        shift_rows = CW'(sr);
        shift      = SW'(s);
        start      = 1'b1;
        busy_cyc   = 0;
        n_out      = 0;
        n_in       = 0;
        last_cnt   = 0;
        seen_valid = 0;
        start_cyc  = cyc + 1;
        cycle();
        start      = 1'b0;
        pass_rows  = '1;
        shift_rows = '1;
        shift      = '1;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int d0 = done_cnt;
        for (int t = 0; t < bound && done_cnt == d0; t++) cycle();
        chk(tag, DW'(done_cnt), DW'(d0 + 1));
        repeat (3) cycle();
        chk({tag, "_single"}, DW'(done_cnt), DW'(d0 + 1));
        chk({tag, "_drained"}, DW'(exp_q.size()), DW'(0));
        chk({tag, "_consumed"}, DW'(in_q.size()), DW'(0));
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_ready", DW'(in_ready), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_data", out_data, '0);
        @(posedge clk);
        #1;

        // Pass-only job.
        in_q.push_back(mk(4, 3, 2, 1));
        in_q.push_back(mk(8, 7, 6, 5));
        push_exp(mk(4, 3, 2, 1), 1'b0);
        push_exp(mk(8, 7, 6, 5), 1'b1);
        start_job(2, 0, 0);
        wait_done(200, "t1_done");
        chk("t1_nout", DW'(n_out), DW'(2));
        chk("t1_nin", DW'(n_in), DW'(2));
        chk("t1_last", DW'(last_cnt), DW'(1));
        chk("t1_done_lat", DW'(done_cyc - last_hs), DW'(1));

        // Pass, boundary, shift by one lane, flush.
        in_q.push_back(mk(3, 2, 1, 0));
        in_q.push_back(mk(99, 98, 97, 10));
        in_q.push_back(mk(23, 22, 21, 20));
        in_q.push_back(mk(33, 32, 31, 30));
        push_exp(mk(3, 2, 1, 0), 1'b0);
        push_exp(mk(22, 21, 20, 10), 1'b0);
        push_exp(mk(32, 31, 30, 23), 1'b0);
        push_exp(mk(0, 0, 0, 33), 1'b1);
        start_job(1, 2, 1);
        wait_done(200, "t2_done");
        chk("t2_nout", DW'(n_out), DW'(4));
        chk("t2_nin", DW'(n_in), DW'(4));
        chk("t2_last", DW'(last_cnt), DW'(1));

        // Boundary straight into flush.
        in_q.push_back(mk(77, 12, 11, 10));
        push_exp(mk(0, 12, 11, 10), 1'b1);
        start_job(0, 0, 3);
        wait_done(200, "t3_done");
        chk("t3_nout", DW'(n_out), DW'(1));
        chk("t3_nin", DW'(n_in), DW'(1));

        // Random backpressure and input gaps against the model.
        src.delete();
        for (int i = 0; i < 13; i++) begin
            src.push_back({$urandom, $urandom, $urandom, $urandom});
            in_q.push_back(src[i]);
        end
        model(5, 7, 2);
        rnd_rdy = 1;
        gaps    = 1;
        start_job(5, 7, 2);
        wait_done(2000, "t4_done");
        rnd_rdy = 0;
        gaps    = 0;
        chk("t4_nout", DW'(n_out), DW'(13));
        chk("t4_nin", DW'(n_in), DW'(13));
        chk("t4_last", DW'(last_cnt), DW'(1));

        // Empty job.
        start_job(0, 0, 0);
        wait_done(50, "t5_done");
        chk("t5_valid", DW'(seen_valid), DW'(0));
        chk("t5_busy", DW'(busy_cyc), DW'(2));
        chk("t5_lat", DW'(done_cyc - start_cyc), DW'(2));

        // Reset in the middle of a shift phase.
        src.delete();
        for (int i = 0; i < 7; i++) begin
            src.push_back({$urandom, $urandom, $urandom, $urandom});
            in_q.push_back(src[i]);
        end
        model(0, 6, 1);
        start_job(0, 6, 1);
        for (int t = 0; t < 100 && n_out < 2; t++) cycle();
        chk("t6_progress", DW'(n_out >= 2), DW'(1));
        rst = 1'b1;
        exp_q.delete();
        in_q.delete();
        in_valid = 1'b0;
        d0 = done_cnt;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", DW'(busy), DW'(0));
        chk("t6_valid", DW'(out_valid), DW'(0));
        chk("t6_ready", DW'(in_ready), DW'(0));
        chk("t6_last", DW'(out_last), DW'(0));
        chk("t6_data", out_data, '0);
        chk("t6_done", DW'(done), DW'(0));
        @(posedge clk);
        #1;
        repeat (6) cycle();
        chk("t6_nodone", DW'(done_cnt), DW'(d0));

        // New job with a start edge issued while busy.
        src.delete();
        for (int i = 0; i < 3; i++) begin
            src.push_back({$urandom, $urandom, $urandom, $urandom});
            in_q.push_back(src[i]);
        end
        model(3, 0, 0);
        out_ready = 1'b0;
        start_job(3, 0, 0);
        cycle();
        pass_rows = CW'(1);
        shift     = SW'(1);
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        wait_done(200, "t7_done");
        chk("t7_nout", DW'(n_out), DW'(3));
        chk("t7_nin", DW'(n_in), DW'(3));
        chk("t7_last", DW'(last_cnt), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
